// File: rtl/and_ff_pipe_pkg.sv
// rtl/and_ff_pipe_pkg.sv - shared types, defaults and op helper for and_ff_pipe
package and_ff_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 2;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  // Bitwise unit: callers apply it per bit, so it works for any WIDTH.
  function automatic logic apply_op(input logic a, input logic b, input op_e op);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/and_ff_pipe_slice.sv
// rtl/and_ff_pipe_slice.sv - one valid+data pipeline register with load/hold
module pipe_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  logic             valid_d;
  logic [WIDTH-1:0] data_d;

  // Loading an empty source leaves a bubble but keeps the old data visible.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = src_valid;
      if (src_valid) begin
        data_d = src_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/and_ff_pipe.sv
// rtl/and_ff_pipe.sv - enable-gated, valid/ready pipelined bitwise logic unit
module and_ff_pipe
  import and_ff_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z
);

  logic [WIDTH-1:0] op_result;
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_load;
  logic [DEPTH-1:0] stage_move;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [WIDTH-1:0] src_data   [DEPTH];

  always_comb begin
    op_result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      op_result[i] = apply_op(a[i], b[i], op_e'(op));
    end
  end

  // Ready ripples back from the consumer in one cycle, so a full pipe still
  // accepts a beat on the same edge it drains one.
  always_comb begin
    stage_move = '0;
    stage_load = '0;
    stage_move[DEPTH-1] = stage_valid[DEPTH-1] & out_ready & enable & ~rst;
    stage_load[DEPTH-1] = enable & ~rst & (~stage_valid[DEPTH-1] | stage_move[DEPTH-1]);
    for (int k = DEPTH - 2; k >= 0; k--) begin
      stage_move[k] = stage_valid[k] & stage_load[k+1];
      stage_load[k] = enable & ~rst & (~stage_valid[k] | stage_move[k]);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_valid[k] = in_valid;
      assign src_data[k]  = op_result;
    end else begin : g_tail
      assign src_valid[k] = stage_valid[k-1];
      assign src_data[k]  = stage_data[k-1];
    end

    pipe_slice #(
      .WIDTH(WIDTH)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .load     (stage_load[k]),
      .src_valid(src_valid[k]),
      .src_data (src_data[k]),
      .valid_q  (stage_valid[k]),
      .data_q   (stage_data[k])
    );
  end

  assign in_ready  = stage_load[0];
  assign out_valid = stage_valid[DEPTH-1] & ~rst;
  assign z         = stage_data[DEPTH-1];

endmodule
